// File: rtl/div_chk_pkg.sv
// Shared types and default constants for the divided-clock checker.
package div_chk_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAcq    = 2'd1,
    StMeas   = 2'd2,
    StLocked = 2'd3
  } state_e;

  localparam int unsigned DefCntW      = 8;
  localparam int unsigned DefExpPeriod = 6;
  localparam int unsigned DefExpHigh   = 3;
  localparam int unsigned DefLockCnt   = 4;

endpackage

// File: rtl/dual_edge_sampler.sv
// Samples sig_in on both clk edges and presents one ordered half-cycle pair per clk cycle.
module dual_edge_sampler (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic s_n,
  output logic s_p,
  output logic prev
);

  logic neg_q;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= sig_in;
  end

  // The negedge sample is retimed alongside the posedge sample so the pair stays aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_n  <= 1'b0;
      s_p  <= 1'b0;
      prev <= 1'b0;
    end else begin
      s_n  <= neg_q;
      s_p  <= sig_in;
      prev <= s_p;
    end
  end

endmodule

// File: rtl/div_clk_checker.sv
// Measures period/high time of a divided clock in clk half-cycles, tracks lock and flags errors.
// Define DIV_CHK_DUTY_CHECK_EN to measure and compare the high time as well.
module div_clk_checker
  import div_chk_pkg::*;
#(
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned EXP_PERIOD = DefExpPeriod,
  parameter int unsigned EXP_HIGH   = DefExpHigh,
  parameter int unsigned LOCK_CNT   = DefLockCnt
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period_hc,
  output logic [CNT_W-1:0] high_hc,
  output logic             meas_valid,
  output logic             locked,
  output logic             err
);

  localparam logic [CNT_W:0]   MaxCnt     = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W:0]   ExpPer     = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   One        = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]   Two        = (CNT_W+1)'(2);
  localparam logic [CNT_W-1:0] OneN       = CNT_W'(1);
  localparam logic [CNT_W-1:0] LockTarget = CNT_W'(LOCK_CNT);

  logic s_n, s_p, prev;

  dual_edge_sampler u_sampler (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .s_n    (s_n),
    .s_p    (s_p),
    .prev   (prev)
  );

  logic             rise0, rise1, rise;
  logic [CNT_W:0]   hc_ext, per_w, hc_grow;
  logic             timeout, match, duty_ok, cnt_clr;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] hc_q, hc_d, good_q, good_d, good_inc, period_q, period_d;
  logic             err_q, err_d, mv_q, mv_d;

  assign rise0 = ~prev & s_n;
  assign rise1 = ~s_n & s_p;
  assign rise  = rise0 | rise1;

  // A slot-1 rise closes the period one sample later than a slot-0 rise.
  assign hc_ext   = {1'b0, hc_q};
  assign per_w    = rise1 ? hc_ext + One : hc_ext;
  assign hc_grow  = hc_ext + Two;
  assign timeout  = rise ? (per_w > MaxCnt) : (hc_grow > MaxCnt);
  assign match    = (per_w == ExpPer) && duty_ok;
  assign good_inc = good_q + OneN;

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    err_d    = err_q;
    mv_d     = 1'b0;
    period_d = period_q;
    cnt_clr  = 1'b0;
    if (err_clr) err_d = 1'b0;
    if (!en) begin
      state_d = StIdle;
      good_d  = '0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StAcq;
          good_d  = '0;
          cnt_clr = 1'b1;
        end
        StAcq: begin
          if (rise) state_d = StMeas;
        end
        StMeas, StLocked: begin
          if (timeout) begin
            err_d    = 1'b1;
            state_d  = StAcq;
            good_d   = '0;
            period_d = '1;
            cnt_clr  = 1'b1;
          end else if (rise) begin
            mv_d     = 1'b1;
            period_d = per_w[CNT_W-1:0];
            if (match) begin
              if (state_q == StMeas) begin
                good_d = good_inc;
                if (good_inc == LockTarget) state_d = StLocked;
              end
            end else begin
              good_d  = '0;
              err_d   = 1'b1;
              state_d = StMeas;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    if (cnt_clr)    hc_d = '0;
    else if (rise0) hc_d = Two[CNT_W-1:0];
    else if (rise1) hc_d = One[CNT_W-1:0];
    else            hc_d = hc_grow[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      hc_q     <= '0;
      good_q   <= '0;
      period_q <= '0;
      err_q    <= 1'b0;
      mv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      hc_q     <= hc_d;
      good_q   <= good_d;
      period_q <= period_d;
      err_q    <= err_d;
      mv_q     <= mv_d;
    end
  end

`ifdef DIV_CHK_DUTY_CHECK_EN
  localparam logic [CNT_W-1:0] ExpHigh = CNT_W'(EXP_HIGH);

  logic [CNT_W-1:0] high_q, high_d, high_hc_q;

  // The low s_n of a slot-1 rise adds nothing, so high_q is already the finished count.
  always_comb begin
    high_d = high_q + CNT_W'(s_n) + CNT_W'(s_p);
    if (cnt_clr)    high_d = '0;
    else if (rise0) high_d = OneN + CNT_W'(s_p);
    else if (rise1) high_d = OneN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_q    <= '0;
      high_hc_q <= '0;
    end else begin
      high_q <= high_d;
      if (mv_d) high_hc_q <= high_q;
    end
  end

  assign duty_ok = (high_q == ExpHigh);
  assign high_hc = high_hc_q;
`else
  assign duty_ok = 1'b1;
  assign high_hc = '0;
`endif

  assign period_hc  = period_q;
  assign meas_valid = mv_q;
  assign err        = err_q;
  assign locked     = (state_q == StLocked);

endmodule

// File: tb/tb_div_clk_checker.sv
// Directed bench for div_clk_checker with a half-slot-level reference model.
module tb_div_clk_checker;

  localparam int ExpP   = 6;
  localparam int ExpH   = 3;
  localparam int LockN  = 4;
  localparam int MaxC   = 255;
  localparam int MaxCyc = 1200;
`ifdef DIV_CHK_DUTY_CHECK_EN
  localparam bit Duty = 1'b1;
`else
  localparam bit Duty = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       sig_in = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] period_hc, high_hc;
  logic       meas_valid, locked, err;

  div_clk_checker dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sig_in     (sig_in),
    .err_clr    (err_clr),
    .period_hc  (period_hc),
    .high_hc    (high_hc),
    .meas_valid (meas_valid),
    .locked     (locked),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ph = 0;
  bit hs[0:2*MaxCyc+1];
  bit en_a[0:MaxCyc];
  bit clr_a[0:MaxCyc];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: 0 idle, 1 acquire, 2 measure, 3 locked; m_last is the half-slot index of the last rise.
  int m_state = 0, m_good = 0, m_err = 0, m_mv = 0, m_period = 0, m_high = 0, m_last = 0;

  task automatic model_step(input int t);
    int i0, i1, r, per, hi;
    bit e, c, ok;
    i0 = 2 * (t - 2);
    i1 = i0 + 1;
    e  = en_a[t-1];
    c  = clr_a[t-1];
    r  = -1;
    if (!hs[i0-1] && hs[i0]) r = i0;
    else if (!hs[i0] && hs[i1]) r = i1;
    m_mv = 0;
    if (c) m_err = 0;
    if (!e) begin
      m_state = 0;
      m_good  = 0;
    end else if (m_state == 0) begin
      m_state = 1;
      m_good  = 0;
    end else if (m_state == 1) begin
      if (r >= 0) begin
        m_last  = r;
        m_state = 2;
      end
    end else if ((r >= 0 && (r - m_last) > MaxC) || (r < 0 && (i1 - m_last + 1) > MaxC)) begin
      m_err    = 1;
      m_state  = 1;
      m_good   = 0;
      m_period = MaxC;
    end else if (r >= 0) begin
      per = r - m_last;
      hi  = 0;
      for (int j = m_last; j < r; j++) hi += int'(hs[j]);
      m_mv     = 1;
      m_period = per;
      m_high   = Duty ? hi : 0;
      ok = (per == ExpP) && (!Duty || hi == ExpH);
      if (ok) begin
        if (m_state == 2) begin
          m_good++;
          if (m_good == LockN) m_state = 3;
        end
      end else begin
        m_good  = 0;
        m_err   = 1;
        m_state = 2;
      end
      m_last = r;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_state = 0; m_good = 0; m_err = 0; m_mv = 0; m_period = 0; m_high = 0;
      check("rst_period", int'(period_hc), 0);
      check("rst_high", int'(high_hc), 0);
      check("rst_mv", int'(meas_valid), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_err", int'(err), 0);
    end else if (cyc >= 3) begin
      model_step(cyc);
      check("meas_valid", int'(meas_valid), m_mv);
      check("locked", int'(locked), int'(m_state == 3));
      check("err", int'(err), m_err);
      check("period_hc", int'(period_hc), m_period);
      check("high_hc", int'(high_hc), m_high);
    end
  end

  // One clk cycle of stimulus: sig_in follows a p-half-slot pattern that is high for h slots.
  task automatic tick(input int p, input int h, input bit e, input bit c, input bit r);
    int k;
    @(posedge clk);
    #1;
    k = cyc;
    if (k >= MaxCyc) begin
      $display("FAIL stimulus_overflow: got %0d expected below %0d", k, MaxCyc);
      $fatal(1);
    end
    rst     = r;
    en      = e;
    err_clr = c;
    sig_in  = (ph % p) < h;
    en_a[k] = e;
    clr_a[k] = c;
    hs[2*k] = sig_in;
    ph++;
    @(negedge clk);
    #1;
    sig_in = (ph % p) < h;
    hs[2*k+1] = sig_in;
    ph++;
  endtask

  task automatic run(input int n, input int p, input int h, input bit e);
    for (int i = 0; i < n; i++) tick(p, h, e, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) tick(6, 3, 1'b0, 1'b0, 1'b1);
    check("lit_reset_period", int'(period_hc), 0);
    check("lit_reset_err", int'(err), 0);
    run(3, 6, 3, 1'b0);

    run(30, 6, 3, 1'b1);
    check("lit_div3_period", int'(period_hc), 6);
    check("lit_div3_high", int'(high_hc), Duty ? 3 : 0);
    check("lit_div3_locked", int'(locked), 1);
    check("lit_div3_err", int'(err), 0);
    check("model_div3_period", m_period, 6);

    run(30, 6, 4, 1'b1);
    check("lit_posonly_period", int'(period_hc), 6);
    check("lit_posonly_high", int'(high_hc), Duty ? 4 : 0);
    check("lit_posonly_err", int'(err), Duty ? 1 : 0);
    check("lit_posonly_locked", int'(locked), Duty ? 0 : 1);

    run(30, 6, 3, 1'b1);
    check("lit_relock", int'(locked), 1);
    tick(6, 3, 1'b1, 1'b1, 1'b0);
    tick(6, 3, 1'b1, 1'b0, 1'b0);
    check("lit_clr_err", int'(err), 0);
    check("lit_clr_locked", int'(locked), 1);

    for (int i = 0; i < 20; i++) tick(8, 4, 1'b1, i[0], 1'b0);
    run(10, 8, 4, 1'b1);
    check("lit_div4_period", int'(period_hc), 8);
    check("lit_div4_err", int'(err), 1);
    check("lit_div4_locked", int'(locked), 0);

    run(30, 6, 3, 1'b1);
    check("lit_div4_relock", int'(locked), 1);
    check("lit_div4_err_kept", int'(err), 1);
    tick(6, 3, 1'b1, 1'b1, 1'b0);
    run(5, 6, 3, 1'b1);
    run(140, 1, 1, 1'b1);
    check("lit_stuck1_period", int'(period_hc), 255);
    check("lit_stuck1_err", int'(err), 1);
    check("lit_stuck1_locked", int'(locked), 0);
    check("lit_stuck1_mv", int'(meas_valid), 0);

    run(30, 6, 3, 1'b1);
    run(140, 1, 0, 1'b1);
    check("lit_stuck0_period", int'(period_hc), 255);
    run(30, 6, 3, 1'b1);
    check("lit_pre_rst_locked", int'(locked), 1);
    tick(6, 3, 1'b0, 1'b0, 1'b1);
    check("lit_midrst_locked", int'(locked), 0);
    check("lit_midrst_err", int'(err), 0);
    check("lit_midrst_period", int'(period_hc), 0);
    tick(6, 3, 1'b0, 1'b0, 1'b1);
    run(3, 6, 3, 1'b0);
    run(30, 6, 3, 1'b1);
    check("lit_post_rst_locked", int'(locked), 1);

    run(10, 8, 4, 1'b1);
    run(30, 6, 3, 1'b1);
    check("lit_pre_en_locked", int'(locked), 1);
    tick(6, 3, 1'b0, 1'b0, 1'b0);
    tick(6, 3, 1'b1, 1'b0, 1'b0);
    check("lit_en_low_locked", int'(locked), 0);
    check("lit_en_low_err", int'(err), 1);
    run(8, 6, 3, 1'b1);
    check("lit_en_not_yet_locked", int'(locked), 0);
    run(20, 6, 3, 1'b1);
    check("lit_en_relocked", int'(locked), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_clk_checker.md
Name: div_clk_checker

Overview:
- Downstream monitor for the odd-ratio 50%-duty clock divider.
- Samples the divided clock on both edges of the source clock `clk` and measures its period and high time in `clk` half-cycles.
- Compares each measurement against expected values, reports lock, and flags any deviation.
- Used in bring-up and self-test to prove divider ratio and duty before the divided clock is handed to consumers.

Parameters:
- CNT_W, 8, width of half-cycle counters and measurement outputs.
- EXP_PERIOD, 6, expected period in half-cycles (div3 = 6).
- EXP_HIGH, 3, expected high time in half-cycles (div3 50% = 3).
- LOCK_CNT, 4, consecutive matching periods required to assert locked; must be ≥1.

Ports:
- clk  in  1  source clock; the divider runs on this clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  monitor enable; low forces IDLE.
- sig_in  in  1  divided clock under test; synchronous to clk edges.
- err_clr  in  1  single-cycle pulse; clears err.
- period_hc  out  CNT_W  last measured period in half-cycles.
- high_hc  out  CNT_W  last measured high time in half-cycles.
- meas_valid  out  1  one-cycle pulse when period_hc/high_hc update.
- locked  out  1  LOCK_CNT consecutive matches seen, no mismatch since.
- err  out  1  sticky mismatch/timeout flag.

Behaviour:
- Reset values:
  - period_hc = 0, high_hc = 0.
  - meas_valid, locked, err = 0.
  - Counters = 0; state = IDLE.
- Sampling:
  - s_n is captured on negedge clk; s_p is captured on posedge clk.
  - At each posedge, the ordered half-cycle pair is (s_n, s_p); prev holds the last s_p.
  - A rise exists if prev=0 and s_n=1 (slot 0), or s_n=0 and s_p=1 (slot 1). At most one rise can occur per cycle.
- Counting:
  - hc_cnt counts samples from a rise (the first high sample counts as 1) up to, but excluding, the next rise.
  - high_cnt counts high samples over the same window.
  - Both restart from the rise slot within the same cycle.
- Outputs are registered. meas_valid pulses on the clk cycle after the posedge whose pair contains the completing rise.
- Match: period == EXP_PERIOD, and (when the duty check is compiled in) high == EXP_HIGH.
- State machine:
  - IDLE: counters cleared, locked=0. Goes to ACQ when en=1.
  - ACQ: waits for the first rise and discards the partial period. On rise, goes to MEAS.
  - MEAS: every rise pulses meas_valid.
    - Match: good_cnt increments.
    - Mismatch: good_cnt=0, err=1.
    - good_cnt reaching LOCK_CNT: goes to LOCKED, locked=1.
  - LOCKED: every rise pulses meas_valid. A mismatch sets err=1, locked=0, good_cnt=0 and returns to MEAS.
  - en=0 in any state: IDLE next cycle, locked=0. err is kept.
- Timeout: if hc_cnt would exceed 2^CNT_W−1 in MEAS or LOCKED:
  - err=1, locked=0, next state ACQ.
  - period_hc=all-ones, no meas_valid.
  - This covers a stuck-high or stuck-low sig_in.
- err_clr: clears err next cycle. If a mismatch occurs in the same cycle, set wins.
- rst mid-operation: everything returns to reset values immediately; ACQ is re-entered only via IDLE with en.

Optional Feature:
- DIV_CHK_DUTY_CHECK_EN defined: high_hc is reported, and the match requires high == EXP_HIGH.
- Not defined: high_cnt logic is removed, high_hc is tied to 0, and only the period is compared.

Decomposition:
- Package div_chk_pkg holds:
  - the state enum (IDLE, ACQ, MEAS, LOCKED);
  - the default CNT_W, EXP_PERIOD, EXP_HIGH and LOCK_CNT constants.
- Sub-module dual_edge_sampler contains:
  - the negedge and posedge capture flops with async rst;
  - outputs s_n, s_p and prev.
- The top holds the counters, compare logic and FSM.

Test Plan:
- en=1, sig_in from a div3 50% divider: meas_valid every 3 clk with period_hc=6 and high_hc=3; locked after 4 periods; err=0.
- sig_in from div3 posedge-only output (high 2 clk, low 1 clk): period 6, high 4. With DIV_CHK_DUTY_CHECK_EN, err=1 and never locked. Without it, locked and err=0.
- sig_in divide-by-4 (period 8) after lock: next meas_valid shows 8; err=1, locked=0; relock only after 4 matching periods.
- sig_in stuck at 1 after lock: err=1, period_hc=255, state ACQ, locked=0; no meas_valid.
- err_clr pulse with matching input: err=0 next cycle, locked retained. err_clr coinciding with a mismatch: err stays 1.
- rst asserted mid-LOCKED: all outputs 0 immediately. en toggled low for 1 cycle: locked=0, err kept, 4 new periods needed to relock.
